// File: rtl/i2c_bit_ctrl_if.sv
// Command-side bus between the byte sequencer (master) and the I2C bit engine (slave).
interface i2c_bit_ctrl_if #(
  parameter int QW = 16
);
  logic          ena;
  logic [QW-1:0] quarter;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic          din;
  logic          cmd_ack;
  logic          dout;
  logic          al;
  logic          busy;

  modport master (
    output ena, quarter, cmd, cmd_valid, din,
    input  cmd_ack, dout, al, busy
  );

  modport slave (
    input  ena, quarter, cmd, cmd_valid, din,
    output cmd_ack, dout, al, busy
  );
endinterface

// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level master: one START/STOP/WRITE/READ primitive per command in four Q-cycle phases.
// Unstretched latency 4*Q cycles to cmd_ack; slave clock stretching holds the phase counter.
module i2c_bit_ctrl #(
  parameter int QW = 16
) (
  input  logic          sysclk_i,
  input  logic          reset_n_i,
  i2c_bit_ctrl_if.slave bus,
  input  logic          scl_i,
  output logic          scl_oen_o,
  input  logic          sda_i,
  output logic          sda_oen_o
);
  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_STOP  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b100;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_A    = 3'd1;
  localparam logic [2:0] ST_B    = 3'd2;
  localparam logic [2:0] ST_C    = 3'd3;
  localparam logic [2:0] ST_D    = 3'd4;

  logic          scl_m, scl_s, sda_m, sda_s, sda_d;
  logic [1:0]    scl_age, sda_age;
  logic [2:0]    state, cmd_r;
  logic          din_r;
  logic [QW-1:0] q_r, cnt;
  logic          ack_q, al_q, dout_q, busy_q;

  logic          scl_settled, sda_settled, hold, phase_end, accept, al_hit;
  logic [QW-1:0] q_eff;

  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= scl_i;
      scl_s <= scl_m;
      sda_m <= sda_i;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  // Edges since each line was last released; the synced copy only reflects the pad after two.
  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scl_age <= 2'd3;
      sda_age <= 2'd3;
    end else begin
      if (!scl_oen_o)            scl_age <= 2'd0;
      else if (scl_age != 2'd3)  scl_age <= scl_age + 2'd1;
      if (!sda_oen_o)            sda_age <= 2'd0;
      else if (sda_age != 2'd3)  sda_age <= sda_age + 2'd1;
    end
  end

  always_comb begin
    scl_settled = scl_age[1];
    sda_settled = sda_age[1];
    q_eff       = (bus.quarter == '0) ? QW'(1) : bus.quarter;
    // A freshly released SCL still reads low through the synchroniser; only a settled low is a stretch.
    hold        = (state != ST_IDLE) && scl_oen_o && scl_settled && !scl_s;
    phase_end   = (state != ST_IDLE) && (cnt == '0) && !hold;
    accept      = (state == ST_IDLE) && bus.ena && bus.cmd_valid &&
                  (bus.cmd inside {CMD_START, CMD_STOP, CMD_WRITE, CMD_READ});
    al_hit      = scl_s && !sda_s && scl_settled && sda_settled &&
                  (((cmd_r == CMD_START) && (state == ST_B)) ||
                   ((cmd_r == CMD_WRITE) && din_r && ((state == ST_B) || (state == ST_C))) ||
                   ((cmd_r == CMD_STOP) && (state == ST_D) && phase_end));
  end

  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_IDLE;
      cmd_r     <= 3'b000;
      din_r     <= 1'b0;
      q_r       <= QW'(1);
      cnt       <= '0;
      scl_oen_o <= 1'b1;
      sda_oen_o <= 1'b1;
      ack_q     <= 1'b0;
      al_q      <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      al_q  <= 1'b0;
      if (!bus.ena) begin
        state     <= ST_IDLE;
        scl_oen_o <= 1'b1;
        sda_oen_o <= 1'b1;
      end else if (accept) begin
        state <= ST_A;
        cmd_r <= bus.cmd;
        din_r <= bus.din;
        q_r   <= q_eff;
        cnt   <= q_eff - QW'(1);
        case (bus.cmd)
          CMD_START: sda_oen_o <= 1'b1;
          CMD_STOP: begin
            sda_oen_o <= 1'b0;
            scl_oen_o <= 1'b0;
          end
          CMD_WRITE: begin
            sda_oen_o <= bus.din;
            scl_oen_o <= 1'b0;
          end
          default: begin
            sda_oen_o <= 1'b1;
            scl_oen_o <= 1'b0;
          end
        endcase
      end else if (al_hit) begin
        al_q      <= 1'b1;
        state     <= ST_IDLE;
        scl_oen_o <= 1'b1;
        sda_oen_o <= 1'b1;
      end else if (state != ST_IDLE) begin
        if (!phase_end) begin
          if (!hold) cnt <= cnt - QW'(1);
        end else begin
          cnt <= q_r - QW'(1);
          case (state)
            ST_A: begin
              state     <= ST_B;
              scl_oen_o <= 1'b1;
            end
            ST_B: begin
              state <= ST_C;
              if (cmd_r == CMD_START) sda_oen_o <= 1'b0;
            end
            ST_C: begin
              state <= ST_D;
              if (cmd_r == CMD_STOP) sda_oen_o <= 1'b1;
              else                   scl_oen_o <= 1'b0;
              if (cmd_r == CMD_READ) dout_q <= sda_s;
            end
            default: begin
              state <= ST_IDLE;
              ack_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Bus-busy follows START/STOP conditions seen on the wire, whoever generated them.
  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i)                     busy_q <= 1'b0;
    else if (!bus.ena)                  busy_q <= 1'b0;
    else if (scl_s && sda_d && !sda_s)  busy_q <= 1'b1;
    else if (scl_s && !sda_d && sda_s)  busy_q <= 1'b0;
  end

  assign bus.cmd_ack = ack_q;
  assign bus.al      = al_q;
  assign bus.dout    = dout_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Scoreboarded bench for i2c_bit_ctrl: directed timing/stretch/arbitration cases plus random bit streams.
module tb_i2c_bit_ctrl;
  localparam int QW = 16;
  localparam logic [2:0] C_NOP = 3'b000, C_START = 3'b001, C_STOP = 3'b010;
  localparam logic [2:0] C_WRITE = 3'b011, C_READ = 3'b100, C_BAD = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_oen, sda_oen, scl_pad, sda_pad;
  logic scl_low = 1'b0, sda_low = 1'b0;

  assign scl_pad = scl_oen & ~scl_low;
  assign sda_pad = sda_oen & ~sda_low;

  i2c_bit_ctrl_if #(.QW(QW)) bus();

  i2c_bit_ctrl #(.QW(QW)) dut (
    .sysclk_i  (clk),
    .reset_n_i (rst_n),
    .bus       (bus),
    .scl_i     (scl_pad),
    .scl_oen_o (scl_oen),
    .sda_i     (sda_pad),
    .sda_oen_o (sda_oen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nvec = 0, nfail = 0;

  typedef struct {
    int   kind;     // 0 = ack, 1 = arbitration lost
    int   at;
    int   tol;
    bit   is_read;
    logic dout;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  logic prev_ev = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    nvec++;
    if (got < lo || got > hi) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_ev) chk("pulse_width", int'(bus.cmd_ack | bus.al), 0);
      prev_ev = bus.cmd_ack | bus.al;
      if (bus.cmd_ack || bus.al) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", int'({bus.cmd_ack, bus.al}), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_flag", int'(bus.cmd_ack), (mon_e.kind == 0) ? 1 : 0);
          chk("al_flag", int'(bus.al), (mon_e.kind == 1) ? 1 : 0);
          chk_rng("event_cycle", cyc, mon_e.at - mon_e.tol, mon_e.at + mon_e.tol);
          if (mon_e.is_read && mon_e.kind == 0) chk("dout", int'(bus.dout), int'(mon_e.dout));
        end
      end
    end
  end

  // Reference: accepted on the edge after cmd_valid rises; completes 4*max(Q,1) cycles later plus stretch.
  task automatic issue(input logic [2:0] c, input logic d, input int q, input int kind,
                       input logic dexp, input int extra, input int tol, output int t);
    int qe;
    qe = (q == 0) ? 1 : q;
    @(posedge clk); #1;
    bus.cmd = c; bus.din = d; bus.quarter = 16'(q); bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    bus.cmd_valid = 1'b0; bus.cmd = C_NOP;
    if (kind >= 0) sb.push_back('{kind, t + 4 * qe + extra, tol, (c == C_READ), dexp});
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("completion_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic count_window(input int len, output int scl_hi, output int sda_lo);
    scl_hi = 0; sda_lo = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (scl_oen) scl_hi++;
      if (!sda_oen) sda_lo++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t, hi, lo, q, nb;
    logic bitv, rd;
    bus.ena = 1'b1; bus.cmd = C_NOP; bus.cmd_valid = 1'b0; bus.din = 1'b0; bus.quarter = 16'd4;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_scl_oen", int'(scl_oen), 1);
    chk("rst_sda_oen", int'(sda_oen), 1);
    chk("rst_ack", int'(bus.cmd_ack), 0);
    chk("rst_al", int'(bus.al), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_dout", int'(bus.dout), 0);

    // NOP and an illegal code held valid: nothing may happen
    @(posedge clk); #1;
    bus.cmd = C_NOP; bus.cmd_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1 bus.cmd = C_BAD;
    repeat (6) @(posedge clk);
    #1 bus.cmd_valid = 1'b0; bus.cmd = C_NOP;
    repeat (20) @(negedge clk);
    chk("nop_scl_oen", int'(scl_oen), 1);
    chk("nop_sda_oen", int'(sda_oen), 1);

    // START timing with Q=4
    issue(C_START, 1'b0, 4, 0, 1'b0, 0, 0, t);
    wait_neg(t + 7);  chk("start_sda_pre", int'(sda_oen), 1);
    wait_neg(t + 8);  chk("start_sda_fall", int'(sda_oen), 0);
    wait_neg(t + 11); chk("start_scl_pre", int'(scl_oen), 1);
    chk("start_busy", int'(bus.busy), 1);
    wait_neg(t + 12); chk("start_scl_fall", int'(scl_oen), 0);
    wait_done(100);

    issue(C_WRITE, 1'b0, 4, 0, 1'b0, 0, 0, t);
    count_window(16, hi, lo);
    chk("wr0_scl_high", hi, 8);
    chk("wr0_sda_low", lo, 16);
    wait_done(100);

    sda_low = 1'b1;
    issue(C_READ, 1'b0, 4, 0, 1'b0, 0, 0, t);
    count_window(16, hi, lo);
    chk("rd0_scl_high", hi, 8);
    chk("rd0_sda_low", lo, 0);
    wait_done(100);
    sda_low = 1'b0;

    issue(C_READ, 1'b0, 4, 0, 1'b1, 0, 0, t);
    wait_done(100);

    // Slave stretches SCL for 20 cycles from the start of phase B
    issue(C_WRITE, 1'b1, 4, 0, 1'b0, 20, 2, t);
    scl_low = 1'b1;
    repeat (24) @(posedge clk);
    #1 scl_low = 1'b0;
    wait_done(200);

    // Another master pulls SDA low while we send a 1 with SCL high
    issue(C_WRITE, 1'b1, 4, 1, 1'b0, -8, 2, t);
    repeat (5) @(posedge clk);
    #1 sda_low = 1'b1;
    wait_done(100);
    chk("al_scl_released", int'(scl_oen), 1);
    chk("al_sda_released", int'(sda_oen), 1);
    repeat (2) @(negedge clk);
    sda_low = 1'b0;
    repeat (6) @(negedge clk);

    issue(C_START, 1'b0, 4, 0, 1'b0, 0, 0, t);
    wait_done(100);
    chk("busy_after_start", int'(bus.busy), 1);

    issue(C_STOP, 1'b0, 4, 0, 1'b0, 0, 0, t);
    wait_neg(t + 11); chk("stop_sda_held", int'(sda_oen), 0);
    wait_neg(t + 12); chk("stop_sda_release", int'(sda_oen), 1);
    wait_done(100);
    chk("busy_after_stop", int'(bus.busy), 0);

    // Core disabled during READ phase B
    issue(C_READ, 1'b0, 4, -1, 1'b0, 0, 0, t);
    repeat (5) @(posedge clk);
    #1 bus.ena = 1'b0;
    wait_neg(t + 6);
    chk("abort_scl_oen", int'(scl_oen), 1);
    chk("abort_sda_oen", int'(sda_oen), 1);
    chk("abort_busy", int'(bus.busy), 0);
    repeat (24) @(negedge clk);
    bus.ena = 1'b1;
    repeat (4) @(negedge clk);

    // Random frames: START, random WRITE/READ bits at random Q (0 means 1), STOP
    for (int r = 0; r < 6; r++) begin
      q = $urandom_range(0, 6);
      issue(C_START, 1'b0, q, 0, 1'b0, 0, 0, t);
      wait_done(100);
      nb = $urandom_range(3, 8);
      for (int b = 0; b < nb; b++) begin
        q = $urandom_range(0, 6);
        rd = 1'($urandom_range(0, 1));
        bitv = 1'($urandom_range(0, 1));
        if (rd) begin
          sda_low = ~bitv;
          issue(C_READ, 1'b0, q, 0, bitv, 0, 0, t);
        end else begin
          issue(C_WRITE, bitv, q, 0, 1'b0, 0, 0, t);
        end
        wait_done(100);
        sda_low = 1'b0;
      end
      q = $urandom_range(0, 6);
      issue(C_STOP, 1'b0, q, 0, 1'b0, 0, 0, t);
      wait_done(100);
    end

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
